// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: the two master request/response ports and the shared RAM
// port of the data-memory arbiter, bundled for connection to dmem_arbiter.
//   slave  : the arbiter's view (requests and RAM read data in, everything else out)
//   master : the surrounding system's view (core, loader and RAM)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Master 0: core memory stage
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [BE_W-1:0]   m0_be;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    // Master 1: debug/DMA loader
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [BE_W-1:0]   m1_be;
    logic              m1_lock;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    // Shared synchronous RAM port
    logic              s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [BE_W-1:0]   s_be;
    logic [DATA_W-1:0] s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_lock,
        input  s_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_we, s_addr, s_wdata, s_be
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_lock,
        output s_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_we, s_addr, s_wdata, s_be
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data-RAM port between the core memory
// stage (master 0) and a debug/DMA loader (master 1). Grants are combinational,
// contention is round-robin, and read data returns one cycle after the grant
// to whichever master issued the read. A withheld m0_gnt stalls the core.
//
// Build option DMEM_ARB_LOCK_EN: when defined, master 1 may hold the port for
// back-to-back bursts via m1_lock, limited to MAX_LOCK consecutive locked
// grants while master 0 waits, after which master 0 is forced in for one
// cycle. When undefined, m1_lock is ignored and arbitration is pure round-robin.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input logic           clk,
    input logic           n_rst,
    dmem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    if (MAX_LOCK < 1) begin : gBadMaxLock
        $error("dmem_arbiter: MAX_LOCK must be at least 1");
    end

    logic              gnt0;
    logic              gnt1;
    logic              lastM1;      // 1 = master 1 owned the most recent grant
    logic              pendValid;   // a read was granted last cycle
    logic              pendOwner;   // 1 = that read belongs to master 1
    logic              sWe;
    logic [ADDR_W-1:0] sAddr;
    logic [DATA_W-1:0] sWdata;
    logic [BE_W-1:0]   sBe;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic             prevM1Gnt;
    logic [CNT_W-1:0] lockCnt;
    logic             lockHold;
    logic             forceRel;

    // Master 1 keeps the port while it holds lock and owned the previous cycle;
    // once master 0 has waited through MAX_LOCK locked grants it is let in.
    assign lockHold = bus.m1_lock && bus.m1_req && prevM1Gnt;
    assign forceRel = lockHold && bus.m0_req && (lockCnt == CNT_W'(MAX_LOCK));
`else
    logic unusedLock;
    assign unusedLock = bus.m1_lock;
`endif

    // Same-cycle grant decision from live requests and registered history
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_LOCK_EN
            if (lockHold) begin
                gnt0 = forceRel;
                gnt1 = !forceRel;
            end else
`endif
            begin
                gnt0 = lastM1;
                gnt1 = !lastM1;
            end
        end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
        end
    end

    // Steer the granted master's request onto the RAM port, zero when idle
    always_comb begin
        sWe    = 1'b0;
        sAddr  = '0;
        sWdata = '0;
        sBe    = '0;
        if (gnt0) begin
            sWe    = bus.m0_we;
            sAddr  = bus.m0_addr;
            sWdata = bus.m0_wdata;
            sBe    = bus.m0_be;
        end else if (gnt1) begin
            sWe    = bus.m1_we;
            sAddr  = bus.m1_addr;
            sWdata = bus.m1_wdata;
            sBe    = bus.m1_be;
        end
    end

    // Round-robin pointer and read-return tag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lastM1    <= 1'b1;
            pendValid <= 1'b0;
            pendOwner <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            if (gnt0 || gnt1) begin
                lastM1    <= gnt1;
                pendOwner <= gnt1;
            end
            pendValid <= (gnt0 && !bus.m0_we) || (gnt1 && !bus.m1_we);
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Burst history: who owned last cycle and how long master 0 has waited
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prevM1Gnt <= 1'b0;
            lockCnt   <= '0;
        end else begin
            prevM1Gnt <= gnt1;
            if (gnt0 || !bus.m1_lock) begin
                lockCnt <= '0;
            end else if (gnt1 && lockHold && bus.m0_req
                         && lockCnt != CNT_W'(MAX_LOCK)) begin
                lockCnt <= lockCnt + 1'b1;
            end
        end
    end
`endif

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.s_we      = sWe;
    assign bus.s_addr    = sAddr;
    assign bus.s_wdata   = sWdata;
    assign bus.s_be      = sBe;
    assign bus.m0_rvalid = pendValid && !pendOwner;
    assign bus.m1_rvalid = pendValid && pendOwner;
    assign bus.m0_rdata  = (pendValid && !pendOwner) ? bus.s_rdata : '0;
    assign bus.m1_rdata  = (pendValid && pendOwner)  ? bus.s_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run of dmem_arbiter
// against a behavioural model of the arbitration rules. The RAM returns
// address ^ RKEY one cycle after the address so read data is predictable.
module tb_dmem_arbiter;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          ML   = 3;
    localparam logic [31:0] RKEY = 32'hA5A5_5A5A;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Synchronous RAM stand-in: data for an address appears the next cycle
    always @(posedge clk) bus.s_rdata <= bus.s_addr ^ RKEY;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
        bus.m1_lock = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_rst = 1'b0;
        idle();
        #1;
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0000)
            $display("FAIL reset_handshake: got %b want 0000",
                     {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid});
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0000) errors++;
        checks++;
        if ({bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be} !== 69'd0) begin
            errors++;
            $display("FAIL reset_ram_port: we=%b addr=%h wdata=%h be=%h want all zero",
                     bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be);
        end
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        checks++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata} !== 66'd0) begin
            errors++;
            $display("FAIL reset_release_rvalid: rv0=%b rv1=%b rd0=%h rd1=%h want 0",
                     bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata);
        end
    endtask

    task automatic test_single_m0();
        do_reset();
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1000_0040; bus.m0_be = 4'hF;
        #1;
        checks++;
        if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt: gnt0=%b gnt1=%b want 1 0", bus.m0_gnt, bus.m1_gnt);
        end
        checks++;
        if (bus.s_addr !== 32'h1000_0040 || bus.s_we !== 1'b0) begin
            errors++;
            $display("FAIL single_addr: addr=%h we=%b want 10000040 0", bus.s_addr, bus.s_we);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== (32'h1000_0040 ^ RKEY)) begin
            errors++;
            $display("FAIL single_rdata: rvalid=%b rdata=%h want 1 %h",
                     bus.m0_rvalid, bus.m0_rdata, 32'h1000_0040 ^ RKEY);
        end
        checks++;
        if (bus.m1_rvalid !== 1'b0 || bus.m1_rdata !== 32'd0) begin
            errors++;
            $display("FAIL single_nonowner: m1 rvalid=%b rdata=%h want 0 0", bus.m1_rvalid, bus.m1_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_rvalid_once: rv0=%b rv1=%b want 0 0", bus.m0_rvalid, bus.m1_rvalid);
        end
    endtask

    task automatic test_contention();
        logic        expM1;
        logic        prevM1;
        logic [31:0] prevAddr;
        do_reset();
        prevM1 = 1'b0;
        prevAddr = '0;
        for (int i = 0; i < 6; i++) begin
            bus.m0_req = 1'b1; bus.m0_addr = 32'h100 + 32'(i * 4);
            bus.m1_req = 1'b1; bus.m1_addr = 32'h200 + 32'(i * 4);
            #1;
            expM1 = (i % 2) == 1;
            checks++;
            if (bus.m0_gnt !== !expM1 || bus.m1_gnt !== expM1) begin
                errors++;
                $display("FAIL contention_gnt[%0d]: gnt0=%b gnt1=%b want %b %b",
                         i, bus.m0_gnt, bus.m1_gnt, !expM1, expM1);
            end
            if (i > 0) begin
                checks++;
                if (bus.m0_rvalid !== !prevM1 || bus.m1_rvalid !== prevM1 ||
                    (prevM1 ? bus.m1_rdata : bus.m0_rdata) !== (prevAddr ^ RKEY)) begin
                    errors++;
                    $display("FAIL contention_rdata[%0d]: rv0=%b rv1=%b rd0=%h rd1=%h want owner m%0d data %h",
                             i, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata,
                             prevM1, prevAddr ^ RKEY);
                end
            end
            prevM1 = expM1;
            prevAddr = expM1 ? bus.m1_addr : bus.m0_addr;
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_write();
        do_reset();
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h0000_0020;
        bus.m1_wdata = 32'hDEAD_BEEF; bus.m1_be = 4'b0011;
        #1;
        checks++;
        if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL write_gnt: gnt0=%b gnt1=%b want 0 1", bus.m0_gnt, bus.m1_gnt);
        end
        checks++;
        if (bus.s_we !== 1'b1 || bus.s_wdata !== 32'hDEAD_BEEF || bus.s_be !== 4'b0011 ||
            bus.s_addr !== 32'h20) begin
            errors++;
            $display("FAIL write_port: we=%b wdata=%h be=%b addr=%h want 1 deadbeef 0011 00000020",
                     bus.s_we, bus.s_wdata, bus.s_be, bus.s_addr);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvalid: rv0=%b rv1=%b want 0 0", bus.m0_rvalid, bus.m1_rvalid);
        end
    endtask

    task automatic test_lock();
        logic expM1 [7];
`ifdef DMEM_ARB_LOCK_EN
        expM1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        expM1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_addr = 32'h3000 + 32'(i * 4);
            bus.m0_req = (i > 0); bus.m0_addr = 32'h4000;
            #1;
            checks++;
            if (bus.m1_gnt !== expM1[i] || bus.m0_gnt !== !expM1[i]) begin
                errors++;
                $display("FAIL lock_seq[%0d]: gnt0=%b gnt1=%b want %b %b",
                         i, bus.m0_gnt, bus.m1_gnt, !expM1[i], expM1[i]);
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        bus.m1_req = 1'b1; bus.m1_addr = 32'h5000;
        #1;
        checks++;
        if (bus.m1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midreset_gnt: gnt1=%b want 1", bus.m1_gnt);
        end
        @(negedge clk);
        idle();
        n_rst = 1'b0;
        #1;
        checks++;
        if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_during: rv0=%b rv1=%b want 0 0", bus.m0_rvalid, bus.m1_rvalid);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_after[%0d]: rv0=%b rv1=%b want 0 0", i, bus.m0_rvalid, bus.m1_rvalid);
            end
            @(negedge clk);
        end
    endtask

    // Randomized traffic against a rule-level model: who may win given the
    // requests, the last winner and how long master 0 has been kept waiting
    // by a lock; reads come back next cycle as address ^ RKEY.
    task automatic test_random();
        logic        rq [2];
        logic        wr [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic [3:0]  be [2];
        logic        lk;
        logic        lastWasM1;
        logic        m1OwnedLast;
        int          waitedLocked;
        logic        readDue;
        logic        readForM1;
        logic [31:0] readAddr;
        int          winner;
        logic        locked;
        logic [136:0] expV;
        logic [136:0] gotV;
        logic [31:0] rd0;
        logic [31:0] rd1;

        do_reset();
        for (int j = 0; j < 2; j++) begin
            rq[j] = 1'b0; wr[j] = 1'b0; ad[j] = '0; wd[j] = '0; be[j] = '0;
        end
        lk = 1'b0;
        lastWasM1 = 1'b1;
        m1OwnedLast = 1'b0;
        waitedLocked = 0;
        readDue = 1'b0;
        readForM1 = 1'b0;
        readAddr = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int j = 0; j < 2; j++) begin
                if (!rq[j]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        rq[j] = 1'b1;
                        wr[j] = $urandom_range(0, 1) == 1;
                        ad[j] = $urandom;
                        wd[j] = $urandom;
                        be[j] = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 99) < 5) begin
                    rq[j] = 1'b0;
                end
            end
            if ($urandom_range(0, 99) < 10) lk = !lk;

            bus.m0_req = rq[0]; bus.m0_we = wr[0]; bus.m0_addr = ad[0]; bus.m0_wdata = wd[0]; bus.m0_be = be[0];
            bus.m1_req = rq[1]; bus.m1_we = wr[1]; bus.m1_addr = ad[1]; bus.m1_wdata = wd[1]; bus.m1_be = be[1];
            bus.m1_lock = lk;
            #1;

            locked = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            locked = lk && rq[1] && m1OwnedLast;
`endif
            if (rq[0] && rq[1]) begin
                if (locked) winner = (waitedLocked >= ML) ? 0 : 1;
                else        winner = lastWasM1 ? 0 : 1;
            end else if (rq[0]) winner = 0;
            else if (rq[1])     winner = 1;
            else                winner = -1;

            rd0 = (readDue && !readForM1) ? (readAddr ^ RKEY) : 32'd0;
            rd1 = (readDue && readForM1)  ? (readAddr ^ RKEY) : 32'd0;
            if (winner >= 0)
                expV = {winner == 0, winner == 1, readDue && !readForM1, readDue && readForM1,
                        rd0, rd1, wr[winner], ad[winner], wd[winner], be[winner]};
            else
                expV = {1'b0, 1'b0, readDue && !readForM1, readDue && readForM1,
                        rd0, rd1, 1'b0, 32'd0, 32'd0, 4'd0};
            gotV = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                    bus.m0_rdata, bus.m1_rdata, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be};
            checks++;
            if (gotV !== expV) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h (g0 g1 rv0 rv1 rd0 rd1 we addr wdata be)",
                         cyc, gotV, expV);
            end

`ifdef DMEM_ARB_LOCK_EN
            if (winner == 0 || !lk)
                waitedLocked = 0;
            else if (winner == 1 && locked && rq[0] && waitedLocked < ML)
                waitedLocked++;
`endif
            if (winner >= 0) lastWasM1 = (winner == 1);
            m1OwnedLast = (winner == 1);
            readDue = (winner >= 0) && !wr[winner >= 0 ? winner : 0];
            if (winner >= 0) begin
                readForM1 = (winner == 1);
                readAddr  = ad[winner];
                rq[winner] = 1'b0;
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_m0();
        test_contention();
        test_write();
        test_lock();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single synchronous data-memory port between the pipelined RV32I core's memory stage (master 0) and a debug/DMA loader (master 1). It sits between the core's data-port outputs and the data RAM. It issues a same-cycle grant, steers address, write data and byte enables to the RAM, and routes the one-cycle-late read data back to the master that issued the read. A withheld grant is the core's stall request for the memory stage.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.
- `MAX_LOCK`, default 8: maximum number of consecutive locked master-1 grants while master 0 is waiting.

Ports:
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `m0_req` in 1: master-0 access request.
- `m0_we` in 1: master-0 write enable.
- `m0_addr` in `ADDR_W`: master-0 address.
- `m0_wdata` in `DATA_W`: master-0 write data.
- `m0_be` in `DATA_W/8`: master-0 byte enables.
- `m0_gnt` out 1: master-0 access accepted this cycle.
- `m0_rvalid` out 1: master-0 read data valid.
- `m0_rdata` out `DATA_W`: master-0 read data.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_be`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as master 0, for master 1.
- `m1_lock` in 1: master 1 requests back-to-back ownership (burst).
- `s_we` out 1: RAM write enable.
- `s_addr` out `ADDR_W`: RAM address.
- `s_wdata` out `DATA_W`: RAM write data.
- `s_be` out `DATA_W/8`: RAM byte enables.
- `s_rdata` in `DATA_W`: RAM read data, valid the cycle after the address.

## Operation
- Grant logic is combinational from the requests and the registered state.
- At most one of `m0_gnt`/`m1_gnt` is high in any cycle.
- A grant is only given to a master whose `req` is high.
- Single requester: that requester is granted in the same cycle.
- Both requesting, no lock: round-robin. Grant goes to the master opposite the registered `last` pointer.
- `last` updates to the granted master on every grant and holds when there is no grant.
- Lock: if `m1_lock && m1_req` and master 1 was granted the previous cycle, master 1 keeps the grant regardless of `last`. This continues until `lock_cnt == MAX_LOCK` while `m0_req` is high.
- Forced release: when `lock_cnt` reaches `MAX_LOCK`, master 0 is granted for one cycle, then normal arbitration resumes.
- `lock_cnt` increments on each locked master-1 grant made while `m0_req` is high. It clears on any master-0 grant, or when `m1_lock` is low. It saturates at `MAX_LOCK`.
- RAM side: `s_*` equals the granted master's signals.
- With no grant, `s_we`, `s_be` and `s_addr` are 0; `s_wdata` is don't-care and driven 0.
- Read tagging: on a granted read (`we=0`), the owner tag and a pending bit are registered.
- Next cycle: the owner's `rvalid` is 1 and its `rdata` equals `s_rdata`. The non-owner's `rdata` is 0.
- Writes produce no `rvalid`.
- A master must hold `req` and all request fields stable until it sees `gnt`. Dropping `req` before `gnt` withdraws the request with no side effect.

## Timing
- Grant latency: 0 cycles (combinational).
- Read data latency: 1 cycle after the grant.
- A new grant may be issued in the same cycle as a returning `rvalid`, giving full back-to-back throughput.
- Reset values: `last` = 1, so master 0 wins the first contention. `lock_cnt`, the pending bit and the tag are 0. Both `rvalid` outputs are 0.
- Reset mid-read: the pending read is discarded, and no `rvalid` is asserted after reset release.
- No outputs are registered except `rvalid`; `rdata` is a gated pass-through.
- The `MAX_LOCK` counter width is `$clog2(MAX_LOCK+1)`. `MAX_LOCK` = 0 is illegal.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: `m1_lock`, `lock_cnt` and forced release are implemented as described.
- Not defined: the `m1_lock` port remains but is ignored, `lock_cnt` is absent, and arbitration is pure round-robin.

## Test plan
- **Reset, then only master 0:** `m0_req=1`, read at 0x1000_0040 → `m0_gnt=1` the same cycle and `s_addr=0x1000_0040`. Next cycle `m0_rvalid=1` and `m0_rdata=s_rdata`; `m1_rvalid=0` throughout.
- **Simultaneous first requests:** both request on the first cycle after reset → `m0_gnt` (`last`=1). Next cycle, both still requesting → `m1_gnt`. Grants alternate thereafter.
- **Write:** master 1 writes 0xDEAD_BEEF with be=4'b0011 → `s_we=1`, `s_wdata=0xDEAD_BEEF`, `s_be=4'b0011`. No `rvalid` next cycle.
- **Lock with MAX_LOCK=3:** master 1 holds `m1_lock`/`m1_req`; `m0_req` rises → exactly 3 further `m1_gnt` cycles, then `m0_gnt` for one cycle, then round-robin.
- **Lock, macro undefined:** same stimulus → grants alternate from the first contended cycle.
- **Reset mid-read:** `n_rst` is asserted in the cycle after a granted read → `m0_rvalid` and `m1_rvalid` both stay 0 after reset release.
